split_norm: RTL and testbench

SPLIT_NORM -- requirements
Module: split_norm

---
 rtl/split_norm_pkg.sv | 18 +
 rtl/split_norm_add.sv | 21 ++
 rtl/split_norm.sv | 100 ++++++++++
 tb/tb_split_norm.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/split_norm_pkg.sv
// Shared constants and types for the split_norm digit normaliser.
// Holds the default digit width, carry width and FSM state encoding.
package split_norm_pkg;

  localparam int DW_DEFAULT = 4;
  localparam int CARRY_W    = 2;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Output slot can take a new digit when empty or being drained this cycle.
  function automatic logic slot_free(input logic valid, input logic ready);
    return !valid || ready;
  endfunction

endpackage

// File: rtl/split_norm_add.sv
// Adds a zero-extended partial sum to the running carry and splits the
// result into a DW-bit digit and the carry into the next digit position.
module split_norm_add
  import split_norm_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW:0]         data_i,
  input  logic [CARRY_W-1:0]  carry_i,
  output logic [DW-1:0]       digit_o,
  output logic [CARRY_W-1:0]  carry_o
);

  logic [DW+1:0] sum;

  // Max sum is (2^(DW+1)-1) + 2, so the upper two bits never exceed 2.
  assign sum     = {1'b0, data_i} + {{DW{1'b0}}, carry_i};
  assign digit_o = sum[DW-1:0];
  assign carry_o = sum[DW+1:DW];

endmodule

// File: rtl/split_norm.sv
// Streams partial sums of an operand (LS first) and emits normalised digits,
// appending one extra flush digit when the final beat leaves a carry.
module split_norm
  import split_norm_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW:0]   in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  state_e               state_q, state_d;
  logic [CARRY_W-1:0]   carry_q, carry_d;
  logic                 out_valid_q, out_valid_d;
  logic [DW-1:0]        out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;

  logic [DW-1:0]        add_digit;
  logic [CARRY_W-1:0]   add_carry;
  logic                 free;
  logic                 accept;

  split_norm_add #(.DW(DW)) u_add (
    .data_i  (in_data),
    .carry_i (carry_q),
    .digit_o (add_digit),
    .carry_o (add_carry)
  );

  assign free     = slot_free(out_valid_q, out_ready);
  assign in_ready = (state_q == ST_RUN) && free;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    unique case (state_q)
      ST_RUN: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = add_digit;
          carry_d     = add_carry;
          out_last_d  = 1'b0;
          if (in_last) begin
            if (add_carry == '0) begin
              out_last_d = 1'b1;
            end else begin
              state_d = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        // Residual carry becomes the operand's most-significant digit.
        if (free) begin
          out_valid_d = 1'b1;
          out_data_d  = DW'(carry_q);
          out_last_d  = 1'b1;
          carry_d     = '0;
          state_d     = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      carry_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_split_norm.sv
// Scoreboard bench for split_norm: an operand's digits are predicted from its
// numeric value, and a monitor compares every digit the DUT hands over.
module tb_split_norm;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW:0]   in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;

  int vectors = 0;
  int miscompares = 0;
  bit rand_rdy = 1'b0;
  logic [DW:0] exp_q[$];

  split_norm #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: operand value V = sum(beat_i << DW*i); digits are V in base 2^DW
  // over n positions, plus one extra digit when V does not fit in n digits.
  task automatic push_expected(input int n, input logic [DW:0] b[8]);
    longint v = 0;
    longint top;
    for (int i = 0; i < n; i++) v += longint'(b[i]) << (DW * i);
    top = v >> (DW * n);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] dg;
      dg = DW'((v >> (DW * i)) & ((64'd1 << DW) - 1));
      exp_q.push_back({(i == n - 1) && (top == 0), dg});
    end
    if (top != 0) exp_q.push_back({1'b1, DW'(top)});
  endtask

  task automatic send_beat(input logic [DW:0] d, input logic l);
    int cnt = 0;
    logic acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cnt++;
      if (!acc && cnt > 500) begin
        vectors++;
        miscompares++;
        $display("FAIL beat_accept_timeout: in_ready stuck at %0b expected 1", in_ready);
        break;
      end
    end
    in_valid = 1'b0;
    in_data  = (DW+1)'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic send_op(input int n, input logic [DW:0] b[8], input int max_gap);
    push_expected(n, b);
    for (int i = 0; i < n; i++) begin
      send_beat(b[i], i == n - 1);
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(posedge clk);
      #0;
    end
  endtask

  task automatic drain();
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < 1000) begin
      @(posedge clk);
      cnt++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d digits outstanding, expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: pops on every handshake and checks stability while stalled.
  initial begin
    bit held = 1'b0;
    logic [DW-1:0] hd;
    logic hl;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, hd);
          chk("hold_last", out_last, hl);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_digit: got %0h last %0b, expected none", out_data, out_last);
          end else begin
            logic [DW:0] e;
            e = exp_q.pop_front();
            chk("digit", out_data, e[DW-1:0]);
            chk("digit_last", out_last, e[DW]);
          end
        end
        held = out_valid && !out_ready;
        hd = out_data;
        hl = out_last;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [DW:0] b[8];
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // No-carry two-beat operand.
    b[0] = 5'h0F; b[1] = 5'h01;
    send_op(2, b, 0);
    drain();

    // Carry chain ending in a flush; in_ready drops for exactly one cycle.
    send_beat(5'h1F, 1'b0);
    exp_q.push_back({1'b0, 4'hF});
    exp_q.push_back({1'b0, 4'h0});
    exp_q.push_back({1'b1, 4'h2});
    send_beat(5'h1F, 1'b1);
    @(negedge clk);
    chk("flush_in_ready_low", in_ready, 0);
    @(negedge clk);
    chk("flush_in_ready_back", in_ready, 1);
    drain();

    // Single-beat operand with flush.
    b[0] = 5'h13;
    send_op(1, b, 0);
    drain();

    // Downstream stall mid-stream.
    b[0] = 5'h08; b[1] = 5'h09; b[2] = 5'h0A;
    fork
      send_op(3, b, 0);
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_out_valid", out_valid, 1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset while a flush digit is pending.
    out_ready = 1'b0;
    send_beat(5'h1F, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_flush_out_valid", out_valid, 0);
    chk("rst_flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    b[0] = 5'h02;
    send_op(1, b, 0);
    drain();

    // Back-to-back operands; the second must not inherit the first carry.
    b[0] = 5'h10;
    send_op(1, b, 0);
    b[0] = 5'h05;
    send_op(1, b, 0);
    drain();

    // Randomised operands with random gaps and backpressure.
    rand_rdy = 1'b1;
    for (int k = 0; k < 80; k++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        b[i] = ($urandom_range(0, 2) == 0) ? 5'h1F : (DW+1)'($urandom);
      send_op(n, b, ($urandom_range(0, 1) == 0) ? 0 : 2);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
